// File: rtl/ifetch_mem.sv
// Instruction fetch unit with an embedded program memory: load the program, then stream words from start_pc to end_pc.
// Optional per-word even parity checking is enabled with the IFETCH_PARITY_EN macro.
module ifetch_mem #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ld_en,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [DATA_W-1:0] ld_data,
    input  logic              start,
    input  logic [ADDR_W-1:0] start_pc,
    input  logic [ADDR_W-1:0] end_pc,
    input  logic              jump,
    input  logic [ADDR_W-1:0] jump_pc,
    input  logic              instr_ready,
    output logic [DATA_W-1:0] instr,
    output logic [ADDR_W-1:0] pc,
    output logic              instr_valid,
    output logic              busy,
    output logic              done,
    output logic              parity_err
);
    localparam int DEPTH = 2**ADDR_W;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FETCH = 2'd1;
    localparam logic [1:0] S_VALID = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

`ifdef IFETCH_PARITY_EN
    localparam int MEM_W = DATA_W + 1;
`else
    localparam int MEM_W = DATA_W;
`endif

    logic [MEM_W-1:0]  mem [DEPTH];
    logic [MEM_W-1:0]  word_in;
    logic [1:0]        state_reg, state_next;
    logic [ADDR_W-1:0] pc_reg, pc_next;
    logic [ADDR_W-1:0] end_reg, end_next;
    logic [DATA_W-1:0] instr_reg;
    logic              idle_like;
    logic              wr_en;
    logic              handshake;

    assign idle_like = (state_reg == S_IDLE) || (state_reg == S_DONE);
    // Reset wins over a load in the same cycle; memory itself is never cleared.
    assign wr_en     = ld_en && idle_like && !reset;
    assign handshake = (state_reg == S_VALID) && instr_ready;

`ifdef IFETCH_PARITY_EN
    assign word_in = {^ld_data, ld_data};
`else
    assign word_in = ld_data;
`endif

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[ld_addr] <= word_in;
        end
    end

    always_comb begin
        state_next = state_reg;
        pc_next    = pc_reg;
        end_next   = end_reg;
        case (state_reg)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_next = S_FETCH;
                    pc_next    = start_pc;
                    end_next   = end_pc;
                end
            end
            S_FETCH: state_next = S_VALID;
            S_VALID: begin
                if (handshake) begin
                    if (jump) begin
                        state_next = S_FETCH;
                        pc_next    = jump_pc;
                    end else if (pc_reg == end_reg) begin
                        state_next = S_DONE;
                    end else begin
                        state_next = S_FETCH;
                        pc_next    = pc_reg + 1'b1;
                    end
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= S_IDLE;
            pc_reg    <= '0;
            end_reg   <= '0;
            instr_reg <= '0;
        end else begin
            state_reg <= state_next;
            pc_reg    <= pc_next;
            end_reg   <= end_next;
            if (state_reg == S_FETCH) begin
                instr_reg <= mem[pc_reg][DATA_W-1:0];
            end
        end
    end

`ifdef IFETCH_PARITY_EN
    logic parity_err_reg;

    // Stored bit is even parity of the data, so XOR over the whole word is 1 on mismatch.
    always_ff @(posedge clk) begin
        if (reset) begin
            parity_err_reg <= 1'b0;
        end else if (state_reg == S_FETCH) begin
            parity_err_reg <= ^mem[pc_reg];
        end
    end

    assign parity_err = parity_err_reg;
`else
    assign parity_err = 1'b0;
`endif

    assign instr       = instr_reg;
    assign pc          = pc_reg;
    assign instr_valid = (state_reg == S_VALID);
    assign busy        = (state_reg == S_FETCH) || (state_reg == S_VALID);
    assign done        = (state_reg == S_DONE);

endmodule

// File: tb/tb_ifetch_mem.sv
// Directed testbench for ifetch_mem: program load, sequential fetch, wrap, stall, jump, reset and parity.
module tb_ifetch_mem;
    localparam int DATA_W = 32;
    localparam int ADDR_W = 3;

    logic              clk = 1'b0;
    logic              reset;
    logic              ld_en;
    logic [ADDR_W-1:0] ld_addr;
    logic [DATA_W-1:0] ld_data;
    logic              start;
    logic [ADDR_W-1:0] start_pc;
    logic [ADDR_W-1:0] end_pc;
    logic              jump;
    logic [ADDR_W-1:0] jump_pc;
    logic              instr_ready;
    logic [DATA_W-1:0] instr;
    logic [ADDR_W-1:0] pc;
    logic              instr_valid;
    logic              busy;
    logic              done;
    logic              parity_err;

    int n_checks = 0;
    int n_fails  = 0;
    logic par_flip = 1'b0;
    logic [DATA_W-1:0] prog [8];

    ifetch_mem #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .reset(reset), .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
        .start(start), .start_pc(start_pc), .end_pc(end_pc), .jump(jump), .jump_pc(jump_pc),
        .instr_ready(instr_ready), .instr(instr), .pc(pc), .instr_valid(instr_valid),
        .busy(busy), .done(done), .parity_err(parity_err)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Called just after the edge that entered FETCH; leaves the DUT in VALID.
    task automatic expect_fetch(input logic [ADDR_W-1:0] epc);
        chk("fetch_busy", {31'b0, busy}, 32'd1);
        chk("fetch_valid", {31'b0, instr_valid}, 32'd0);
        step();
        chk("valid_flag", {31'b0, instr_valid}, 32'd1);
        chk("valid_pc", {29'b0, pc}, {29'b0, epc});
        chk("valid_instr", instr, prog[epc]);
        chk("valid_parity", {31'b0, parity_err}, {31'b0, par_flip && (epc == 3'd1)});
    endtask

    task automatic check_done();
        chk("done_flag", {31'b0, done}, 32'd1);
        chk("done_busy", {31'b0, busy}, 32'd0);
        chk("done_valid", {31'b0, instr_valid}, 32'd0);
    endtask

    task automatic do_start(input logic [ADDR_W-1:0] s, input logic [ADDR_W-1:0] e);
        start = 1'b1; start_pc = s; end_pc = e;
        step();
        start = 1'b0;
    endtask

    initial begin
        prog[0] = 32'h2401002D; prog[1] = 32'h2402FFEC;
        prog[2] = 32'h2403FFC4; prog[3] = 32'h2404001E;
        for (int i = 4; i < 8; i++) prog[i] = 32'h0000_0100 + i;

        reset = 1'b1; ld_en = 1'b0; ld_addr = '0; ld_data = '0; start = 1'b0;
        start_pc = '0; end_pc = '0; jump = 1'b0; jump_pc = '0; instr_ready = 1'b1;
        step();
        step();
        chk("rst_instr", instr, 32'h0);
        chk("rst_pc", {29'b0, pc}, 32'h0);
        chk("rst_busy_done", {29'b0, instr_valid, busy, done}, 32'h0);
        chk("rst_parity", {31'b0, parity_err}, 32'h0);
        reset = 1'b0;

        for (int i = 0; i < 8; i++) begin
            ld_en = 1'b1; ld_addr = i[ADDR_W-1:0]; ld_data = prog[i];
            step();
        end
        ld_en = 1'b0;
        $display("load: 8 words written");

        // Sequential run 0..3 with one instruction every other cycle.
        do_start(3'd0, 3'd3);
        for (int i = 0; i < 4; i++) begin
            expect_fetch(i[ADDR_W-1:0]);
            step();
        end
        check_done();
        $display("run 0..3 complete");

        // Wrap from DEPTH-1 back to 0.
        do_start(3'd6, 3'd1);
        expect_fetch(3'd6); step();
        expect_fetch(3'd7); step();
        expect_fetch(3'd0); step();
        expect_fetch(3'd1); step();
        check_done();
        $display("run 6..1 wrap complete");

        // Stall at pc=2 for 5 cycles; loads in this window must be ignored.
        do_start(3'd0, 3'd3);
        expect_fetch(3'd0); step();
        expect_fetch(3'd1); step();
        expect_fetch(3'd2);
        instr_ready = 1'b0; ld_en = 1'b1; ld_addr = 3'd2; ld_data = 32'hDEADBEEF;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("stall_valid", {31'b0, instr_valid}, 32'd1);
            chk("stall_pc", {29'b0, pc}, 32'd2);
            chk("stall_instr", instr, prog[2]);
        end
        instr_ready = 1'b1; ld_en = 1'b0;
        step();
        expect_fetch(3'd3); step();
        check_done();
        $display("stall at pc=2 complete");

        // Jump without ready has no effect; jump in FETCH is ignored; jump on handshake redirects.
        do_start(3'd0, 3'd7);
        expect_fetch(3'd0); step();
        expect_fetch(3'd1);
        instr_ready = 1'b0; jump = 1'b1; jump_pc = 3'd4;
        step();
        chk("jump_noready_pc", {29'b0, pc}, 32'd1);
        chk("jump_noready_valid", {31'b0, instr_valid}, 32'd1);
        instr_ready = 1'b1; jump_pc = 3'd5;
        step();
        jump_pc = 3'd2;
        expect_fetch(3'd5);
        jump = 1'b0;
        step();
        expect_fetch(3'd6); step();
        expect_fetch(3'd7); step();
        check_done();
        $display("jump to 5 complete");

        // Reset in VALID at pc=2 beats concurrent start and load.
        do_start(3'd0, 3'd3);
        expect_fetch(3'd0); step();
        expect_fetch(3'd1); step();
        expect_fetch(3'd2);
        reset = 1'b1; start = 1'b1; ld_en = 1'b1; ld_addr = 3'd0; ld_data = 32'h12345678;
        step();
        reset = 1'b0; start = 1'b0; ld_en = 1'b0;
        chk("midrst_outs", {29'b0, instr_valid, busy, done}, 32'h0);
        chk("midrst_pc", {29'b0, pc}, 32'h0);
        chk("midrst_instr", instr, 32'h0);
        chk("midrst_parity", {31'b0, parity_err}, 32'h0);
        step();
        chk("midrst_idle", {30'b0, busy, done}, 32'h0);

`ifdef IFETCH_PARITY_EN
        dut.mem[1][DATA_W] = ~dut.mem[1][DATA_W];
        par_flip = 1'b1;
`endif
        do_start(3'd0, 3'd3);
        for (int i = 0; i < 4; i++) begin
            expect_fetch(i[ADDR_W-1:0]);
            step();
        end
        check_done();
        $display("restart after reset complete");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule
